// File: rtl/nn_layer_sequencer.sv
// Sequences one inference: clear the network, load the input words, then request each layer in turn.
// Latency: net_clr one cycle after start, fill for FILL_WORDS cycles, then one layer_req per layer until its ack.
// Backpressure: each layer holds off the sequence through its ack; a per-layer watchdog turns a hang into ERROR.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS = 2,
    parameter int FILL_WORDS = 2,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic                                                  abort,
    input  logic [NUM_LAYERS-1:0]                                 layer_ack,
    output logic                                                  net_clr,
    output logic                                                  fill,
    output logic [NUM_LAYERS-1:0]                                 layer_req,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  error,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] err_layer,
    output logic [CNT_W-1:0]                                      run_cycles
);

    localparam int LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int FCW = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
    localparam int WDW = $clog2(TIMEOUT);

    localparam logic [LW-1:0]  LAST_LAYER = LW'(NUM_LAYERS - 1);
    localparam logic [FCW-1:0] FILL_LAST  = FCW'(FILL_WORDS - 1);
    localparam logic [WDW-1:0] WDOG_LAST  = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [LW-1:0]  layer_idx;
    logic [LW-1:0]  layer_idx_n;
    logic [LW-1:0]  err_layer_n;
    logic [FCW-1:0] fill_cnt;
    logic [FCW-1:0] fill_cnt_n;
    logic [WDW-1:0] wdog;
    logic [WDW-1:0] wdog_n;
    logic           cnt_clr;
    logic           cnt_inc;

    // Next-state, next-register values and outputs decoded from the registered state only.
    always_comb begin
        state_n     = state;
        layer_idx_n = layer_idx;
        fill_cnt_n  = fill_cnt;
        wdog_n      = wdog;
        err_layer_n = err_layer;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        net_clr     = 1'b0;
        fill        = 1'b0;
        layer_req   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                    cnt_clr = 1'b1;
                end
            end
            S_CLEAR: begin
                net_clr    = 1'b1;
                busy       = 1'b1;
                cnt_inc    = 1'b1;
                fill_cnt_n = '0;
                state_n    = S_FILL;
            end
            S_FILL: begin
                fill    = 1'b1;
                busy    = 1'b1;
                cnt_inc = 1'b1;
                if (fill_cnt == FILL_LAST) begin
                    state_n     = S_RUN;
                    layer_idx_n = '0;
                    wdog_n      = '0;
                end else begin
                    fill_cnt_n = fill_cnt + FCW'(1);
                end
            end
            S_RUN: begin
                layer_req[layer_idx] = 1'b1;
                busy                 = 1'b1;
                cnt_inc              = 1'b1;
                // Only the ack of the layer currently requested is looked at.
                if (layer_ack[layer_idx]) begin
                    if (layer_idx == LAST_LAYER) begin
                        state_n = S_DONE;
                    end else begin
                        layer_idx_n = layer_idx + LW'(1);
                        wdog_n      = '0;
                    end
                end else if (wdog == WDOG_LAST) begin
                    state_n     = S_ERROR;
                    err_layer_n = layer_idx;
                end else begin
                    wdog_n = wdog + WDW'(1);
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_n = S_CLEAR;
                    cnt_clr = 1'b1;
                end
            end
            S_ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort beats every other transition; the latency counter keeps its value.
        if (abort) begin
            state_n     = S_IDLE;
            layer_idx_n = layer_idx;
            fill_cnt_n  = fill_cnt;
            wdog_n      = wdog;
            err_layer_n = err_layer;
            cnt_clr     = 1'b0;
            cnt_inc     = 1'b0;
        end
    end

    // State and datapath registers; the latency counter saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            layer_idx  <= '0;
            fill_cnt   <= '0;
            wdog       <= '0;
            err_layer  <= '0;
            run_cycles <= '0;
        end else begin
            state     <= state_n;
            layer_idx <= layer_idx_n;
            fill_cnt  <= fill_cnt_n;
            wdog      <= wdog_n;
            err_layer <= err_layer_n;
            if (cnt_clr) begin
                run_cycles <= '0;
            end else if (cnt_inc && (run_cycles != {CNT_W{1'b1}})) begin
                run_cycles <= run_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with NUM_LAYERS=2, FILL_WORDS=2, TIMEOUT=16, CNT_W=16.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// Acks are driven by hand, standing in for the sticky layer acks of the network.
module tb_nn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  layer_ack;
    logic        net_clr;
    logic        fill;
    logic [1:0]  layer_req;
    logic        busy;
    logic        done;
    logic        error;
    logic [0:0]  err_layer;
    logic [15:0] run_cycles;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector layout: {net_clr, fill, layer_req[1:0], busy, done, error}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_CLR  = 7'b1000100;
    localparam logic [6:0] O_FILL = 7'b0100100;
    localparam logic [6:0] O_REQ0 = 7'b0001100;
    localparam logic [6:0] O_REQ1 = 7'b0010100;
    localparam logic [6:0] O_DONE = 7'b0000010;
    localparam logic [6:0] O_ERR  = 7'b0000001;

    always #5 clk = ~clk;

    nn_layer_sequencer #(
        .NUM_LAYERS(2),
        .FILL_WORDS(2),
        .TIMEOUT   (16),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .layer_ack (layer_ack),
        .net_clr   (net_clr),
        .fill      (fill),
        .layer_req (layer_req),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_layer (err_layer),
        .run_cycles(run_cycles)
    );

    function automatic logic [31:0] outs();
        return 32'({net_clr, fill, layer_req, busy, done, error});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL sim_time_limit: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        layer_ack = 2'b00;
        tick();
        tick();
        chk("rst_outs", outs(), 32'(O_IDLE));
        chk("rst_cycles", 32'(run_cycles), 32'd0);
        chk("rst_err_layer", 32'(err_layer), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_outs", outs(), 32'(O_IDLE));
        chk("idle_cycles", 32'(run_cycles), 32'd0);

        // Normal run: ack0 in the third req0 cycle, ack1 in the second req1 cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_c1_clr", outs(), 32'(O_CLR));
        tick(); chk("r1_c2_fill", outs(), 32'(O_FILL));
        tick(); chk("r1_c3_fill", outs(), 32'(O_FILL));
        tick(); chk("r1_c4_req0", outs(), 32'(O_REQ0));
        tick(); chk("r1_c5_req0", outs(), 32'(O_REQ0));
        tick(); chk("r1_c6_req0", outs(), 32'(O_REQ0));
        layer_ack = 2'b01;
        tick(); chk("r1_c7_req1", outs(), 32'(O_REQ1));
        tick(); chk("r1_c8_req1", outs(), 32'(O_REQ1));
        layer_ack = 2'b11;
        tick(); chk("r1_c9_done", outs(), 32'(O_DONE));
        chk("r1_cycles", 32'(run_cycles), 32'd8);
        tick(); chk("r1_c10_done", outs(), 32'(O_DONE));
        chk("r1_cycles_frozen", 32'(run_cycles), 32'd8);

        // Restart from DONE, then reset in the middle of RUN.
        layer_ack = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2_clr", outs(), 32'(O_CLR));
        chk("r2_cycles_cleared", 32'(run_cycles), 32'd0);
        tick(); chk("r2_fill_a", outs(), 32'(O_FILL));
        tick(); chk("r2_fill_b", outs(), 32'(O_FILL));
        chk("r2_cycles_fill", 32'(run_cycles), 32'd2);
        tick(); chk("r2_req0_a", outs(), 32'(O_REQ0));
        chk("r2_cycles_run", 32'(run_cycles), 32'd3);
        tick(); chk("r2_req0_b", outs(), 32'(O_REQ0));
        rst = 1'b1;
        tick();
        chk("r2_rst_outs", outs(), 32'(O_IDLE));
        chk("r2_rst_cycles", 32'(run_cycles), 32'd0);
        rst = 1'b0;
        tick(); chk("r2_post_rst", outs(), 32'(O_IDLE));

        // Layer 0 acks in its first RUN cycle; layer 1 never acks.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_clr", outs(), 32'(O_CLR));
        tick(); chk("to_fill_a", outs(), 32'(O_FILL));
        tick(); chk("to_fill_b", outs(), 32'(O_FILL));
        layer_ack = 2'b01;
        tick(); chk("to_req0_single", outs(), 32'(O_REQ0));
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("to_req1_%0d", i), outs(), 32'(O_REQ1));
        end
        tick();
        chk("to_error", outs(), 32'(O_ERR));
        chk("to_err_layer", 32'(err_layer), 32'd1);
        chk("to_cycles", 32'(run_cycles), 32'd20);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        chk("to_start_ignored", outs(), 32'(O_ERR));
        chk("to_err_layer_frozen", 32'(err_layer), 32'd1);
        chk("to_cycles_frozen", 32'(run_cycles), 32'd20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        layer_ack = 2'b00;
        chk("to_abort_idle", outs(), 32'(O_IDLE));
        chk("to_abort_cycles", 32'(run_cycles), 32'd20);
        tick(); chk("to_abort_stay", outs(), 32'(O_IDLE));

        // Abort during FILL.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("af_clr", outs(), 32'(O_CLR));
        tick(); chk("af_fill", outs(), 32'(O_FILL));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("af_idle", outs(), 32'(O_IDLE));
        tick();
        tick();
        chk("af_stay_idle", outs(), 32'(O_IDLE));

        // Abort in the same cycle that ack1 arrives.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("aa_clr", outs(), 32'(O_CLR));
        tick();
        tick();
        tick(); chk("aa_req0", outs(), 32'(O_REQ0));
        layer_ack = 2'b01;
        tick(); chk("aa_req1", outs(), 32'(O_REQ1));
        layer_ack = 2'b11;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("aa_idle", outs(), 32'(O_IDLE));
        tick(); chk("aa_no_done", outs(), 32'(O_IDLE));
        layer_ack = 2'b00;

        // Stray ack on layer 1 while layer 0 is requested.
        layer_ack = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sa_clr", outs(), 32'(O_CLR));
        tick();
        tick();
        tick(); chk("sa_req0_a", outs(), 32'(O_REQ0));
        tick(); chk("sa_req0_b", outs(), 32'(O_REQ0));
        tick(); chk("sa_req0_c", outs(), 32'(O_REQ0));
        layer_ack = 2'b11;
        tick(); chk("sa_req1", outs(), 32'(O_REQ1));
        tick(); chk("sa_done", outs(), 32'(O_DONE));
        chk("sa_cycles", 32'(run_cycles), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Top-level scheduler for the fixed-point neural-network datapath. On `start` it clears the network's sticky layer acks, streams `FILL_WORDS` cycles of `fill` into the input-ROM/channel loader, then issues `req` to each layer in order and waits for that layer's `ack`. A per-layer watchdog reports hung layers. A cycle counter reports end-to-end inference latency. It sits between the host/testbench control port and the `req`/`fill`/`ack` pins of the network and layer instances.

## Interface
- `NUM_LAYERS`, 2, number of layers sequenced (≥1)
- `FILL_WORDS`, 2, input words loaded per inference (≥1); `fill` high for exactly this many cycles
- `TIMEOUT`, 1024, max cycles a layer may hold off `ack` (≥2)
- `CNT_W`, 16, width of `run_cycles`
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin inference; sampled only in IDLE and DONE
- `abort`  in  1  return to IDLE next cycle from any state
- `layer_ack`  in  NUM_LAYERS  per-layer level ack; sticky until `net_clr`
- `net_clr`  out  1  one-cycle clear pulse to the network's layer `rst`
- `fill`  out  1  input-load enable
- `layer_req`  out  NUM_LAYERS  one-hot (or zero) request, held until ack
- `busy`  out  1  high in CLEAR, FILL, RUN
- `done`  out  1  high in DONE
- `error`  out  1  high in ERROR
- `err_layer`  out  clog2(NUM_LAYERS) (min 1)  index of the timed-out layer
- `run_cycles`  out  CNT_W  cycles spent in CLEAR+FILL+RUN of the last inference; saturating

## Operation
- States: IDLE, CLEAR, FILL, RUN, DONE, ERROR. Registers: `layer_idx`, `fill_cnt`, `wdog`, `run_cycles`.
- IDLE: all outputs low. `start`=1 → CLEAR; `run_cycles` ← 0.
- CLEAR: `net_clr`=1 for exactly one cycle. Then → FILL with `fill_cnt` ← 0.
- FILL: `fill`=1. `fill_cnt` increments each cycle. At `fill_cnt`==FILL_WORDS-1 → RUN with `layer_idx` ← 0 and `wdog` ← 0.
- RUN: `layer_req[layer_idx]`=1, all other bits 0.
  - If `layer_ack[layer_idx]`=1: if `layer_idx`==NUM_LAYERS-1 → DONE; else `layer_idx`+1 and `wdog` ← 0.
  - Else if `wdog`==TIMEOUT-1: → ERROR with `err_layer` ← `layer_idx`.
  - Else `wdog`+1.
  - Acks on any other layer index are ignored.
- DONE: `done`=1, `run_cycles` frozen. `start`=1 → CLEAR (new run, counter cleared).
- ERROR: `error`=1, `err_layer` and `run_cycles` frozen. `start` is ignored. Only `abort` or `rst` exit.
- `abort`=1 in any state → IDLE next cycle. It overrides every other transition, including an ack arriving in the same cycle. `run_cycles` holds its value.
- `run_cycles` increments in every CLEAR, FILL and RUN cycle. It saturates at 2^CNT_W-1 with no wrap.
- `rst` has priority over `abort`. Reset mid-operation drops `layer_req`, `fill` and `net_clr` in the next cycle, with no partial pulse completion.

## Timing
- Reset values: state IDLE. `net_clr`, `fill`, `layer_req`, `busy`, `done`, `error` = 0. `err_layer` = 0, `run_cycles` = 0.
- All outputs are registered or decoded from the registered state only; no input→output combinational path.
- Start accepted at edge t:
  - `net_clr` high in cycle t+1.
  - `fill` high in cycles t+2 … t+1+FILL_WORDS.
  - `layer_req[0]` high from cycle t+2+FILL_WORDS.
- Ack sampled at edge u:
  - `layer_req[k]` low and `layer_req[k+1]` high from cycle u+1, back-to-back with no gap.
  - For the last layer, `done` rises in cycle u+1.
- An ack already high in the first RUN cycle of a layer is accepted; minimum per-layer cost is 1 cycle.
- Timeout: with no ack, ERROR is entered TIMEOUT cycles after `layer_req[k]` rises.
- Total run_cycles = 1 + FILL_WORDS + Σ(per-layer RUN cycles).

## Test plan
(NUM_LAYERS=2, FILL_WORDS=2, TIMEOUT=16, CNT_W=16)
- Reset then idle 5 cycles → all outputs 0, `run_cycles`=0.
- `start` pulse at cycle 0; ack0 given 3 cycles after req0 rises, ack1 given 2 cycles after req1 rises → `net_clr`@1, `fill`@2–3, req0@4–6, req1@7–8, `done`@9, `run_cycles`=8.
- Never ack layer 1 → req1 high 16 cycles, then `error`=1, `err_layer`=1, `busy`=0; `start` ignored; `abort` → IDLE.
- `abort` asserted during FILL, and separately on the same cycle as ack1 → IDLE next cycle, `done` never rises, `fill`/`layer_req` low.
- `layer_ack[1]` held high during RUN of layer 0 → ignored, req0 stays high until ack0, then req1 one cycle, then `done`.
- Run from DONE with `start` again, and `rst` asserted mid-RUN → second run restarts at `net_clr` with counter cleared; `rst` returns all outputs to reset values next cycle.
